// File: rtl/mem_pkg.sv
// Shared types for the memory query/answer bus: commands, block data,
// block indices, transaction tags and the responder's pipeline entry.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [63:0] mem_blk_t;
  typedef logic [15:0] mem_idx_t;
  typedef logic [3:0]  mem_tag_t;

  // Tag 0 is reserved to mean "no tag" on both ack and ans_tag.
  localparam mem_tag_t MEM_TAG_NONE = 4'd0;

  // Number of encodable tag values, including the reserved 0.
  localparam int MEM_TAG_SPACE = 2 ** $bits(mem_tag_t);

  // One slot of the load-answer shift pipeline. Invalid slots carry
  // tag 0 and blk 0 so the last slot can drive the answer bus directly.
  typedef struct packed {
    logic     valid;
    mem_tag_t tag;
    mem_blk_t blk;
  } mem_pipe_ent_t;

endpackage

// File: rtl/mem_tag_pool.sv
// Tag allocator: in-use bitmap over tags 1..NTAG with a lowest-free
// priority encoder. One tag may be set (alloc) and one cleared (release)
// per cycle. NTAG must not exceed MEM_TAG_SPACE-1.
module mem_tag_pool
  import mem_pkg::*;
#(
  parameter int NTAG = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_tag_t alloc_tag,
  input  mem_tag_t release_tag,
  output mem_tag_t free_tag
);

  // The bitmap spans the whole tag space so any mem_tag_t can index it;
  // bit 0 and bits above NTAG are never set.
  logic [MEM_TAG_SPACE-1:0] in_use_q;
  logic [MEM_TAG_SPACE-1:0] in_use_d;

  // Next bitmap: release the answered tag, mark the newly allocated one.
  // The answering tag is still busy this cycle, so the two never collide.
  always_comb begin
    in_use_d = in_use_q;
    if (release_tag != MEM_TAG_NONE) begin
      in_use_d[release_tag] = 1'b0;
    end
    if (alloc_tag != MEM_TAG_NONE) begin
      in_use_d[alloc_tag] = 1'b1;
    end
  end

  // Lowest-numbered free tag; scanning downward lets the lowest win.
  always_comb begin
    free_tag = MEM_TAG_NONE;
    for (int i = NTAG; i >= 1; i--) begin
      if (!in_use_q[i]) begin
        free_tag = mem_tag_t'(i);
      end
    end
  end

  // Bitmap register; reset frees every tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_use_q <= '0;
    end else begin
      in_use_q <= in_use_d;
    end
  end

  // A tag handed out must have been free.
  a_alloc_free : assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_tag != MEM_TAG_NONE) |-> !in_use_q[alloc_tag]);

  // A tag being answered (and released) must currently be in use.
  a_release_busy : assert property (@(posedge clk) disable iff (!rst_n)
    (release_tag != MEM_TAG_NONE) |-> in_use_q[release_tag]);

endmodule

// File: rtl/mem_responder.sv
// Bus-side memory endpoint. Accepts one query per cycle, acks it
// combinationally with the lowest free tag (0 = rejected, retry), stores
// immediately and answers loads in order exactly LATENCY cycles after
// acceptance. Backing storage is not reset.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int NTAG    = 15
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_cmd_t qry_cmd,
  input  mem_blk_t qry_blk,
  input  mem_idx_t qry_idx,
  output mem_tag_t ack,
  output mem_blk_t ans_blk,
  output mem_tag_t ans_tag
);

  localparam int          ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);

  logic              idx_ok;
  logic              accept;
  logic              load_acc;
  logic              store_acc;
  logic [ADDR_W-1:0] addr;
  mem_tag_t          free_tag;
  mem_tag_t          alloc_tag;
  mem_tag_t          release_tag;

  mem_blk_t          mem_q [DEPTH];
  mem_pipe_ent_t     pipe_q [1:LATENCY];
  mem_pipe_ent_t     pipe_d [1:LATENCY];

  assign addr = qry_idx[ADDR_W-1:0];

  // Acceptance: real command, in-range index and a tag available.
  // Stores consume a tag only for the ack; they never hold one.
  always_comb begin
    idx_ok    = ({1'b0, qry_idx} < DEPTH_LIM);
    accept    = (qry_cmd != MEM_NONE) && idx_ok && (free_tag != MEM_TAG_NONE);
    ack       = accept ? free_tag : MEM_TAG_NONE;
    load_acc  = accept && (qry_cmd == MEM_LOAD);
    store_acc = accept && (qry_cmd == MEM_STORE);
    alloc_tag = load_acc ? free_tag : MEM_TAG_NONE;
  end

  mem_tag_pool #(
    .NTAG (NTAG)
  ) u_tag_pool (
    .clk         (clk),
    .rst_n       (rst_n),
    .alloc_tag   (alloc_tag),
    .release_tag (release_tag),
    .free_tag    (free_tag)
  );

  // Storage write; a store is visible to any load accepted afterwards.
  always_ff @(posedge clk) begin
    if (store_acc) begin
      mem_q[addr] <= qry_blk;
    end
  end

  // Pipeline next state: stage 1 captures the read for an accepted load,
  // later stages shift by one. Empty slots stay all-zero.
  always_comb begin
    for (int i = 1; i <= LATENCY; i++) begin
      pipe_d[i] = '0;
    end
    if (load_acc) begin
      pipe_d[1].valid = 1'b1;
      pipe_d[1].tag   = free_tag;
      pipe_d[1].blk   = mem_q[addr];
    end
    for (int i = 2; i <= LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline registers; reset drops in-flight loads without answering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // The last stage is the answer; its tag is freed at the end of this cycle.
  assign ans_tag     = pipe_q[LATENCY].tag;
  assign ans_blk     = pipe_q[LATENCY].blk;
  assign release_tag = pipe_q[LATENCY].valid ? pipe_q[LATENCY].tag : MEM_TAG_NONE;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector tables, an asynchronous
// mid-operation reset sequence and randomized traffic against a
// queue-based reference model, on a default instance and an NTAG=2 one.
module tb_mem_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_cmd_t a_cmd, b_cmd;
  mem_blk_t a_blk, b_blk, a_ablk, b_ablk;
  mem_idx_t a_idx, b_idx;
  mem_tag_t a_ack, b_ack, a_atag, b_atag;

  mem_responder #(.DEPTH(1024), .LATENCY(4), .NTAG(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .qry_cmd(a_cmd), .qry_blk(a_blk), .qry_idx(a_idx),
    .ack(a_ack), .ans_blk(a_ablk), .ans_tag(a_atag));

  mem_responder #(.DEPTH(1024), .LATENCY(4), .NTAG(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .qry_cmd(b_cmd), .qry_blk(b_blk), .qry_idx(b_idx),
    .ack(b_ack), .ans_blk(b_ablk), .ans_tag(b_atag));

  int total = 0;
  int bad = 0;

  typedef struct {
    bit       rst;
    bit       sel;
    mem_cmd_t cmd;
    mem_idx_t idx;
    mem_blk_t blk;
    mem_tag_t ack;
    mem_tag_t atag;
    bit       cblk;
    mem_blk_t ablk;
  } vec_t;

  typedef struct {
    int       due;
    mem_tag_t tag;
    mem_blk_t data;
    bit       known;
  } pend_t;

  vec_t vecs[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(bit rst, bit sel, mem_cmd_t cmd, mem_idx_t idx, mem_blk_t blk,
                     mem_tag_t ack, mem_tag_t atag, bit cblk, mem_blk_t ablk);
    vec_t v;
    v.rst = rst; v.sel = sel; v.cmd = cmd; v.idx = idx; v.blk = blk;
    v.ack = ack; v.atag = atag; v.cblk = cblk; v.ablk = ablk;
    vecs.push_back(v);
  endtask

  function automatic mem_tag_t cur_ack(bit sel);
    return sel ? b_ack : a_ack;
  endfunction
  function automatic mem_tag_t cur_atag(bit sel);
    return sel ? b_atag : a_atag;
  endfunction
  function automatic mem_blk_t cur_ablk(bit sel);
    return sel ? b_ablk : a_ablk;
  endfunction

  // Drive one query at the falling edge and settle before sampling.
  task automatic apply(bit sel, mem_cmd_t cmd, mem_idx_t idx, mem_blk_t blk);
    @(negedge clk);
    a_cmd = MEM_NONE; a_idx = '0; a_blk = '0;
    b_cmd = MEM_NONE; b_idx = '0; b_blk = '0;
    if (sel) begin
      b_cmd = cmd; b_idx = idx; b_blk = blk;
    end else begin
      a_cmd = cmd; a_idx = idx; a_blk = blk;
    end
    #1;
  endtask

  task automatic show(string tagname, int cyc, bit sel, mem_cmd_t cmd, mem_idx_t idx);
    $display("%s cyc=%0d dut=%s cmd=%s idx=%0d ack=%0d ans_tag=%0d ans_blk=%h",
             tagname, cyc, sel ? "b" : "a", cmd.name(), idx, cur_ack(sel),
             cur_atag(sel), cur_ablk(sel));
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_cmd = MEM_NONE; a_idx = '0; a_blk = '0;
    b_cmd = MEM_NONE; b_idx = '0; b_blk = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table();
    int cyc = 0;
    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        do_reset();
        cyc = 0;
      end
      apply(vecs[i].sel, vecs[i].cmd, vecs[i].idx, vecs[i].blk);
      chk($sformatf("vec%0d.ack", i), cur_ack(vecs[i].sel), vecs[i].ack);
      chk($sformatf("vec%0d.ans_tag", i), cur_atag(vecs[i].sel), vecs[i].atag);
      if (vecs[i].cblk) begin
        chk($sformatf("vec%0d.ans_blk", i), cur_ablk(vecs[i].sel), vecs[i].ablk);
      end
      show("vec", cyc, vecs[i].sel, vecs[i].cmd, vecs[i].idx);
      cyc++;
    end
  endtask

  // Reference model: a tag is busy exactly while its load sits in the
  // outstanding queue (acceptance through answer cycle inclusive).
  task automatic run_random(bit sel, int ntag, int lat, int ncyc);
    pend_t    q[$];
    mem_blk_t shadow[int];
    mem_cmd_t cmd;
    mem_idx_t idx;
    mem_blk_t blk;
    mem_tag_t exp_ack, exp_tag;
    mem_blk_t exp_data;
    bit       chk_data, used;
    int       r;
    pend_t    p;
    do_reset();
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 2) ? MEM_NONE : (r < 4) ? MEM_STORE : MEM_LOAD;
      if (cyc >= ncyc - lat - 1) cmd = MEM_NONE;
      idx = ($urandom_range(0, 9) == 0) ? mem_idx_t'($urandom_range(1020, 1030))
                                        : mem_idx_t'($urandom_range(0, 15));
      blk = {$urandom, $urandom};

      exp_ack = MEM_TAG_NONE;
      if (cmd != MEM_NONE && int'(idx) < 1024) begin
        for (int t = ntag; t >= 1; t--) begin
          used = 1'b0;
          foreach (q[k]) if (int'(q[k].tag) == t) used = 1'b1;
          if (!used) exp_ack = mem_tag_t'(t);
        end
      end
      exp_tag = MEM_TAG_NONE; exp_data = '0; chk_data = 1'b1;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_tag = q[0].tag; exp_data = q[0].data; chk_data = q[0].known;
      end

      apply(sel, cmd, idx, blk);
      chk($sformatf("rnd%0d.%0d.ack", sel, cyc), cur_ack(sel), exp_ack);
      chk($sformatf("rnd%0d.%0d.ans_tag", sel, cyc), cur_atag(sel), exp_tag);
      if (chk_data) chk($sformatf("rnd%0d.%0d.ans_blk", sel, cyc), cur_ablk(sel), exp_data);
      show("rnd", cyc, sel, cmd, idx);

      if (exp_ack != MEM_TAG_NONE) begin
        if (cmd == MEM_STORE) begin
          shadow[int'(idx)] = blk;
        end else begin
          p.due = cyc + lat; p.tag = exp_ack;
          p.known = shadow.exists(int'(idx));
          p.data = p.known ? shadow[int'(idx)] : '0;
          q.push_back(p);
        end
      end
      if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    end
  endtask

  initial begin
    mem_tag_t g3_ack[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    mem_tag_t g3_ans[6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    mem_tag_t g5_ack[12] = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    mem_tag_t g5_ans[12] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd0};
    mem_cmd_t cmd;
    mem_tag_t at;

    a_cmd = MEM_NONE; a_idx = '0; a_blk = '0;
    b_cmd = MEM_NONE; b_idx = '0; b_blk = '0;

    // Single load: ack 1 now, answer tag 1 four cycles later only.
    add(1, 0, MEM_LOAD, 16'd5, 64'd0, 4'd1, 4'd0, 1, 64'd0);
    for (int c = 1; c <= 5; c++)
      add(0, 0, MEM_NONE, 16'd0, 64'd0, 4'd0, (c == 4) ? 4'd1 : 4'd0, c != 4, 64'd0);

    // Store then load the same index on the next cycle.
    add(1, 0, MEM_STORE, 16'd7, 64'hDEAD_BEEF, 4'd1, 4'd0, 1, 64'd0);
    add(0, 0, MEM_LOAD, 16'd7, 64'd0, 4'd1, 4'd0, 1, 64'd0);
    for (int c = 2; c <= 6; c++)
      add(0, 0, MEM_NONE, 16'd0, 64'd0, 4'd0, (c == 5) ? 4'd1 : 4'd0, 1,
          (c == 5) ? 64'hDEAD_BEEF : 64'd0);

    // Fill idx 0..5, then back-to-back loads; tag 1 reused on the 6th.
    for (int c = 0; c <= 16; c++) begin
      cmd = (c < 6) ? MEM_STORE : (c < 12) ? MEM_LOAD : MEM_NONE;
      at = (c >= 10 && c <= 15) ? g3_ans[c-10] : 4'd0;
      add(c == 0, 0, cmd, mem_idx_t'(c % 6), 64'h100 + 64'(c), (c < 6) ? 4'd1 :
          (c < 12) ? g3_ack[c-6] : 4'd0, at, 1, (at != 0) ? 64'h100 + 64'(c - 10) : 64'd0);
    end

    // Out-of-range index: rejected, no answer, no aliasing, tags untouched.
    add(1, 0, MEM_LOAD,  16'd1024, 64'd0,      4'd0, 4'd0, 1, 64'd0);
    add(0, 0, MEM_STORE, 16'd1024, 64'hBAD,    4'd0, 4'd0, 1, 64'd0);
    add(0, 0, MEM_STORE, 16'd1023, 64'hABC,    4'd1, 4'd0, 1, 64'd0);
    add(0, 0, MEM_LOAD,  16'd1023, 64'd0,      4'd1, 4'd0, 1, 64'd0);
    add(0, 0, MEM_LOAD,  16'd1024, 64'd0,      4'd0, 4'd0, 1, 64'd0);
    add(0, 0, MEM_LOAD,  16'd0,    64'd0,      4'd2, 4'd0, 1, 64'd0);
    add(0, 0, MEM_NONE,  16'd0,    64'd0,      4'd0, 4'd0, 1, 64'd0);
    add(0, 0, MEM_NONE,  16'd0,    64'd0,      4'd0, 4'd1, 1, 64'hABC);
    add(0, 0, MEM_NONE,  16'd0,    64'd0,      4'd0, 4'd0, 1, 64'd0);
    add(0, 0, MEM_NONE,  16'd0,    64'd0,      4'd0, 4'd2, 1, 64'h100);
    add(0, 0, MEM_NONE,  16'd0,    64'd0,      4'd0, 4'd0, 1, 64'd0);

    // NTAG=2 instance: exhaustion, then reuse after each answer.
    for (int c = 0; c < 12; c++)
      add(c == 0, 1, (c < 7) ? MEM_LOAD : MEM_NONE, 16'd0, 64'd0, g5_ack[c], g5_ans[c],
          g5_ans[c] == 0, 64'd0);

    run_table();

    // Asynchronous reset while answers are in flight.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(0, MEM_LOAD, mem_idx_t'(c), 64'd0);
      chk($sformatf("mid.ack%0d", c), a_ack, 4'(c + 1));
      show("mid", c, 0, MEM_LOAD, mem_idx_t'(c));
    end
    apply(0, MEM_NONE, 16'd0, 64'd0);
    apply(0, MEM_NONE, 16'd0, 64'd0);
    chk("mid.pre_rst_tag", a_atag, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.rst_tag", a_atag, 4'd0);
    chk("mid.rst_blk", a_ablk, 64'd0);
    show("mid", 4, 0, MEM_NONE, 16'd0);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      apply(0, MEM_NONE, 16'd0, 64'd0);
      chk($sformatf("mid.quiet%0d", c), a_atag, 4'd0);
      show("mid", 5 + c, 0, MEM_NONE, 16'd0);
    end
    apply(0, MEM_LOAD, 16'd1, 64'd0);
    chk("mid.reack", a_ack, 4'd1);
    show("mid", 13, 0, MEM_LOAD, 16'd1);
    for (int c = 1; c <= 4; c++) begin
      apply(0, MEM_NONE, 16'd0, 64'd0);
      chk($sformatf("mid.ans%0d", c), a_atag, (c == 4) ? 4'd1 : 4'd0);
      show("mid", 13 + c, 0, MEM_NONE, 16'd0);
    end

    run_random(0, 15, 4, 300);
    run_random(1, 2, 4, 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
